// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: qualifies raw PLL lock and releases per-domain resets in order
// Ports:
//   clock      - PLL output clock; every flop lives here
//   reset      - synchronous active-high block reset
//   lock_in    - raw PLL LOCK, asynchronous to clock
//   rst_stage  - active-high resets, bit 0 released first
//   ready      - all stages released and lock still held
//   lock_lost  - one-cycle pulse when lock drops after release began
//   loss_count - saturating count of lock_lost pulses
module pll_reset_sequencer #(
   parameter int STABLE_CYCLES = 1024,
   parameter int STAGES        = 3,
   parameter int STAGE_GAP     = 16,
   parameter int CNT_W         = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              lock_in,
   output logic [STAGES-1:0] rst_stage,
   output logic              ready,
   output logic              lock_lost,
   output logic [CNT_W-1:0]  loss_count
);
   localparam int SW = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
   localparam int GW = STAGE_GAP > 1 ? $clog2(STAGE_GAP) : 1;
   localparam int IW = STAGES > 1 ? $clog2(STAGES) : 1;
   typedef enum logic [1:0] {WAIT, STABLE, RELEASE, RUN} state_t;
   state_t state, state_n;
   logic sync1, lock_s;
   logic [SW-1:0] stable_cnt, stable_n;
   logic [GW-1:0] gap_cnt, gap_n;
   logic [IW-1:0] idx, idx_n;
   logic loss_evt, loss_n;
   logic [STAGES-1:0] stage_d;
   always_comb begin
      state_n  = state;
      stable_n = stable_cnt;
      gap_n    = gap_cnt;
      idx_n    = idx;
      loss_n   = 1'b0;
      case (state)
         WAIT: begin
            if (lock_s) begin
               state_n  = STABLE;
               stable_n = '0;
            end
         end
         STABLE: begin
            if (!lock_s) state_n = WAIT;
            else if (stable_cnt == SW'(STABLE_CYCLES-1)) begin
               state_n = RELEASE;
               gap_n   = '0;
               idx_n   = '0;
            end else stable_n = stable_cnt + SW'(1);
         end
         RELEASE: begin
            if (!lock_s) begin
               state_n = WAIT;
               loss_n  = 1'b1;
            end else if (gap_cnt == GW'(STAGE_GAP-1)) begin
               gap_n = '0;
               if (idx == IW'(STAGES-1)) state_n = RUN;
               else idx_n = idx + IW'(1);
            end else gap_n = gap_cnt + GW'(1);
         end
         default: begin
            if (!lock_s) begin
               state_n = WAIT;
               loss_n  = 1'b1;
            end
         end
      endcase
   end
   // Stage mask follows the FSM one edge later: in RELEASE, stages below idx are out of reset
   always_comb begin
      stage_d = '1;
      for (int k = 0; k < STAGES; k++)
         stage_d[k] = (state == RUN) ? 1'b0 : (state == RELEASE && k < int'(idx)) ? 1'b0 : 1'b1;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1      <= 1'b0;
         lock_s     <= 1'b0;
         state      <= WAIT;
         stable_cnt <= '0;
         gap_cnt    <= '0;
         idx        <= '0;
         loss_evt   <= 1'b0;
         rst_stage  <= '1;
         ready      <= 1'b0;
         lock_lost  <= 1'b0;
         loss_count <= '0;
      end else begin
         sync1      <= lock_in;
         lock_s     <= sync1;
         state      <= state_n;
         stable_cnt <= stable_n;
         gap_cnt    <= gap_n;
         idx        <= idx_n;
         loss_evt   <= loss_n;
         rst_stage  <= stage_d;
         ready      <= (state == RUN);
         lock_lost  <= loss_evt;
         if (loss_evt && loss_count != '1) loss_count <= loss_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: random and directed lock patterns checked against a run-length model
module tb_pll_reset_sequencer;
   localparam int SC  = 8;
   localparam int NS  = 3;
   localparam int GAP = 4;
   localparam int CW  = 2;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic lock_in = 1'b0;
   logic [NS-1:0] rst_stage;
   logic ready, lock_lost;
   logic [CW-1:0] loss_count;
   int n_chk = 0;
   int n_fail = 0;
   int smp[$];
   int rl[$];
   int last_rst = -1;
   int exp_cnt = 0;
   pll_reset_sequencer #(.STABLE_CYCLES(SC), .STAGES(NS), .STAGE_GAP(GAP), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .lock_in(lock_in),
      .rst_stage(rst_stage), .ready(ready), .lock_lost(lock_lost), .loss_count(loss_count)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", tag, smp.size() - 1, got, exp);
      end
   endtask
   // Sample history only counts from the edge after the latest reset
   function automatic int rl_at(input int k);
      return (k > last_rst) ? rl[k] : 0;
   endfunction
   function automatic int smp_at(input int k);
      return (k > last_rst) ? smp[k] : 2;
   endfunction
   // Outputs at edge n depend on the lock_in run length ending three edges earlier
   task automatic step(input logic r, input logic l);
      int n, r3;
      logic [NS-1:0] e_rst;
      logic e_rdy, e_ll;
      reset = r;
      lock_in = l;
      @(posedge clock);
      n = smp.size();
      if (r) begin
         last_rst = n;
         smp.push_back(2);
         rl.push_back(0);
      end else begin
         smp.push_back(int'(l));
         rl.push_back(l ? rl_at(n - 1) + 1 : 0);
      end
      r3 = rl_at(n - 3);
      for (int i = 0; i < NS; i++) e_rst[i] = !(r3 >= 1 + SC + (i + 1) * GAP);
      e_rdy = (r3 >= 1 + SC + NS * GAP);
      e_ll = (smp_at(n - 3) == 0) && (rl_at(n - 4) >= SC + 1);
      if (r) exp_cnt = 0;
      else if (e_ll && exp_cnt < (1 << CW) - 1) exp_cnt++;
      #1;
      chk("rst_stage", 32'(rst_stage), 32'(e_rst));
      chk("ready", 32'(ready), 32'(e_rdy));
      chk("lock_lost", 32'(lock_lost), 32'(e_ll));
      chk("loss_count", 32'(loss_count), 32'(exp_cnt));
   endtask
   task automatic hold(input logic r, input logic l, input int cyc);
      repeat (cyc) step(r, l);
   endtask
   initial begin
      hold(1, 0, 4);
      hold(0, 1, 30);
      hold(0, 0, 1);
      hold(0, 1, 30);
      hold(0, 0, 5);
      hold(0, 1, 5);
      hold(0, 0, 1);
      hold(0, 1, 30);
      hold(0, 0, 3);
      hold(0, 1, 17);
      hold(0, 0, 4);
      repeat (5) begin
         hold(0, 1, 30);
         hold(0, 0, 2);
      end
      hold(0, 1, 21);
      step(1, 1);
      hold(0, 1, 30);
      repeat (80) begin
         logic l;
         l = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 19) == 0) step(1, l);
         hold(0, l, l ? $urandom_range(1, 45) : $urandom_range(1, 6));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Consumer side of the PLL lock interface.
- Takes the raw, asynchronous PLL LOCK output and synchronises it into the PLL output clock domain.
- Qualifies lock as stable for a programmable time, then releases a set of per-domain active-high resets one after another.
- Detects loss of lock, re-asserts every reset, and counts loss events for debug.

Parameters:
- STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before any reset is released (>=1).
- STAGES, 3: number of sequenced reset outputs (>=1).
- STAGE_GAP, 16: cycles between successive reset releases (>=1).
- CNT_W, 8: width of the saturating lock-loss counter.

Ports:
- clock, in, 1: PLL output clock; all logic is in this domain.
- reset, in, 1: synchronous, active-high block reset.
- lock_in, in, 1: raw PLL LOCK, asynchronous to clock.
- rst_stage, out, STAGES: active-high reset per downstream domain; bit 0 is released first.
- ready, out, 1: high when all stages are released and lock is held.
- lock_lost, out, 1: single-cycle pulse on loss of lock after release began.
- loss_count, out, CNT_W: number of lock_lost pulses, saturating at all-ones.

Behaviour:
- Reset values (reset high at a clock edge): both synchroniser flops 0, state WAIT, all counters 0, rst_stage all ones, ready 0, lock_lost 0, loss_count 0. Reset overrides every other event in the same cycle, including mid-sequence.
- Synchroniser: two flops. lock_s = second flop. All decisions use lock_s only.
- All outputs are registered. There are no combinational paths from any input to any output.
- FSM states:
  - WAIT: rst_stage all ones, ready 0. If lock_s=1, go to STABLE with stable_cnt=0.
  - STABLE: if lock_s=0, go to WAIT. This is a glitch: no lock_lost pulse, no count. Otherwise stable_cnt++. When stable_cnt reaches STABLE_CYCLES-1 with lock_s=1, go to RELEASE with idx=0 and gap_cnt=0.
  - RELEASE: if lock_s=0, go to WAIT. Otherwise gap_cnt++. When gap_cnt reaches STAGE_GAP-1, clear rst_stage[idx], increment idx, and set gap_cnt=0. Clearing bit STAGES-1 goes to RUN, and ready rises in the same cycle that bit clears.
  - RUN: ready 1, rst_stage all zeros. If lock_s=0, go to WAIT.
- Lock loss from RELEASE or RUN, effective on the next edge:
  - rst_stage returns to all ones.
  - ready goes to 0.
  - lock_lost is 1 for exactly one cycle.
  - loss_count increments unless already all ones.
- Timing: let E0 be the first edge that samples lock_in=1, with lock held thereafter. rst_stage[i] deasserts exactly 3+STABLE_CYCLES+(i+1)*STAGE_GAP cycles after E0. ready asserts together with rst_stage[STAGES-1].
- Released bits never re-assert except on lock loss or reset. rst_stage is monotonic within a sequence.
- Counter widths: sized to hold STABLE_CYCLES-1, STAGE_GAP-1 and STAGES-1. Counters never wrap during normal operation.
- lock_in toggling at any rate never yields a partial release unless lock_s was held for STABLE_CYCLES.

Test Plan (STABLE_CYCLES=8, STAGES=3, STAGE_GAP=4, CNT_W=2):
- Clean lock: reset 4 cycles, then lock_in=1 from E0 -> rst_stage 111 until E0+15, 110 at +15, 100 at +19, 000 at +23; ready=1 at +23; lock_lost never pulses.
- Glitch during qualification: lock_in high 5 cycles, low 1, then high -> no release before 3+8+4 cycles after the final rise; lock_lost stays 0; loss_count=0.
- Loss in RUN: from RUN drop lock_in at edge L -> rst_stage=111 and ready=0 at L+3; lock_lost high exactly at L+3 for 1 cycle; loss_count=1; re-lock repeats the full 15/19/23 sequence.
- Loss mid-RELEASE: drop lock_in once rst_stage=110 -> 111, one lock_lost pulse, loss_count increments.
- Saturation: 5 RUN-state losses -> loss_count reads 1,2,3,3,3.
- Reset mid-sequence: assert reset while rst_stage=100 -> next edge all reset values; loss_count=0; no lock_lost pulse.
